// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle control FSM for the 8-bit bus datapath.
// It fetches one instruction word from din when run is high. It then sequences the
// register-file enables and the ALU controls (Ain, Gin, AddSub, Gout) over T1..T3.
// Optional build macro: PERF_CNT_EN adds a 16-bit instr_cnt output that counts
// completed instructions.
module alu_seq_ctrl #(
    parameter int DATA_W    = 8,
    parameter int REG_SEL_W = 3,
    parameter int NREG      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [NREG-1:0]   rin,
    output logic [NREG-1:0]   rout,
    output logic              din_out,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Gout,
`ifdef PERF_CNT_EN
    output logic              done,
    output logic [15:0]       instr_cnt
`else
    output logic              done
`endif
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_e;
    typedef enum logic [1:0] {OP_MV, OP_MVI, OP_ADD, OP_SUB} op_e;

    state_e                state;
    logic [DATA_W-1:0]     ir;
    op_e                   op;
    logic [REG_SEL_W-1:0]  rx;
    logic [REG_SEL_W-1:0]  ry;
    logic [NREG-1:0]       rx_hot;
    logic [NREG-1:0]       ry_hot;

    // Instruction field split and one-hot register selects
    always_comb begin
        op     = op_e'(ir[DATA_W-1 -: 2]);
        rx     = ir[2*REG_SEL_W-1 -: REG_SEL_W];
        ry     = ir[REG_SEL_W-1:0];
        rx_hot = {{(NREG-1){1'b0}}, 1'b1} << rx;
        ry_hot = {{(NREG-1){1'b0}}, 1'b1} << ry;
    end

    // State sequencing and instruction register capture on the way out of T0
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: if (run) begin
                        ir    <= din;
                        state <= T1;
                    end
                T1: state <= (op == OP_MV || op == OP_MVI) ? T0 : T2;
                T2: state <= T3;
                default: state <= T0;
            endcase
        end
    end

    // Control decode from state and IR; held at zero while reset is asserted
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        rin     = '0;
        rout    = '0;
        din_out = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        Gout    = 1'b0;
        done    = 1'b0;
        if (!rst) begin
            case (state)
                T1: begin
                    case (op)
                        OP_MV: begin
                            rout = ry_hot;
                            rin  = rx_hot;
                            done = 1'b1;
                        end
                        OP_MVI: begin
                            din_out = 1'b1;
                            rin     = rx_hot;
                            done    = 1'b1;
                        end
                        default: begin
                            rout = rx_hot;
                            Ain  = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    rout   = ry_hot;
                    Gin    = 1'b1;
                    AddSub = ~ir[DATA_W-2];
                end
                T3: begin
                    Gout = 1'b1;
                    rin  = rx_hot;
                    done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Completed-instruction counter, free-running with natural 16-bit wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr_cnt <= '0;
        else if (done)
            instr_cnt <= instr_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: table of instructions, per-cycle control
// scoreboard, a small register-file/ALU model driven by the DUT controls, and
// hand-written reset-abort and idle sequences.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] din;
    logic [7:0] rin, rout;
    logic       din_out, Ain, Gin, AddSub, Gout, done;
`ifdef PERF_CNT_EN
    logic [15:0] instr_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DATA_W(8), .REG_SEL_W(3), .NREG(8)) dut (
        .clk(clk), .rst(rst), .run(run), .din(din),
        .rin(rin), .rout(rout), .din_out(din_out),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Gout(Gout),
`ifdef PERF_CNT_EN
        .done(done), .instr_cnt(instr_cnt)
`else
        .done(done)
`endif
    );

    // Datapath model: bus, register file, ALU A/G registers
    logic [7:0] rf [8];
    logic [7:0] a_reg = 8'h00;
    logic [7:0] g_reg = 8'h00;
    logic [7:0] bus;

    always_comb begin
        bus = 8'h00;
        if (din_out)   bus = din;
        else if (Gout) bus = g_reg;
        else begin
            for (int i = 0; i < 8; i++)
                if (rout[i]) bus = rf[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (rin[i]) rf[i] <= bus;
        if (Ain) a_reg <= bus;
        if (Gin) g_reg <= AddSub ? a_reg + bus : a_reg - bus;
    end

    // Scoreboard of expected per-cycle control words
    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       din_out;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       gout;
        logic       done;
    } ctl_t;

    ctl_t ctl_q[$];

    function automatic ctl_t actual_ctl();
        ctl_t a;
        a.rin = rin; a.rout = rout; a.din_out = din_out; a.ain = Ain;
        a.gin = Gin; a.addsub = AddSub; a.gout = Gout; a.done = done;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_invariants();
        check("bus_drivers_le1", 32'(($countones(rout) + 32'(din_out) + 32'(Gout)) <= 1), 32'd1);
        check("rin_onehot0", 32'($onehot0(rin)), 32'd1);
        check("rout_onehot0", 32'($onehot0(rout)), 32'd1);
        check("ain_gin_excl", 32'(Ain & Gin), 32'd0);
    endtask

    task automatic pop_check(input string tag);
        ctl_t e;
        if (ctl_q.size() == 0) begin
            check({tag, "_underflow"}, 32'd1, 32'd0);
        end else begin
            e = ctl_q.pop_front();
            check(tag, 32'(actual_ctl()), 32'(e));
        end
        check_invariants();
    endtask

    // Expected control words for one instruction, starting with its T0 cycle
    task automatic push_expected(input logic [7:0] instr);
        ctl_t w;
        logic [7:0] bx, by;
        bx = 8'h01 << instr[5:3];
        by = 8'h01 << instr[2:0];
        ctl_q.push_back('0);
        w = '0;
        case (instr[7:6])
            2'b00: begin
                w.rout = by; w.rin = bx; w.done = 1'b1; ctl_q.push_back(w);
            end
            2'b01: begin
                w.din_out = 1'b1; w.rin = bx; w.done = 1'b1; ctl_q.push_back(w);
            end
            default: begin
                w.rout = bx; w.ain = 1'b1; ctl_q.push_back(w);
                w = '0; w.rout = by; w.gin = 1'b1; w.addsub = ~instr[6]; ctl_q.push_back(w);
                w = '0; w.gout = 1'b1; w.rin = bx; w.done = 1'b1; ctl_q.push_back(w);
            end
        endcase
    endtask

    // Runs one instruction from a negedge in T0; ends on the negedge after done
    task automatic exec(input logic [7:0] instr, input logic [7:0] imm, input logic hold);
        push_expected(instr);
        pop_check($sformatf("t0_%h", instr));
        run = 1'b1;
        din = instr;
        while (ctl_q.size() > 0) begin
            @(negedge clk);
            run = hold;
            din = imm;
            pop_check($sformatf("ctl_%h", instr));
        end
        exp_cnt++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [7:0] imm;
        int         chk_reg;
        logic [7:0] chk_val;
        logic       hold;
    } vec_t;

    vec_t vecs[$];

    logic       abort_win  = 1'b0;
    logic       abort_done = 1'b0;
    logic [7:0] r0_saved;

    always @(posedge clk)
        if (abort_win && done) abort_done <= 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ctl_t w;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;

        vecs.push_back('{8'h4A, 8'h25, 1, 8'h25, 1'b0}); // mvi R1, 25
        vecs.push_back('{8'h11, 8'h00, 2, 8'h25, 1'b0}); // mv R2, R1
        vecs.push_back('{8'h40, 8'hF0, 0, 8'hF0, 1'b1}); // mvi R0, F0
        vecs.push_back('{8'h81, 8'h00, 0, 8'h15, 1'b1}); // add R0, R1 (wraps)
        vecs.push_back('{8'h58, 8'h05, 3, 8'h05, 1'b1}); // mvi R3, 05
        vecs.push_back('{8'hD9, 8'h00, 3, 8'hE0, 1'b1}); // sub R3, R1
        vecs.push_back('{8'h60, 8'h77, 4, 8'h77, 1'b0}); // mvi R4, 77
        vecs.push_back('{8'h24, 8'h00, 4, 8'h77, 1'b0}); // mv R4, R4
        vecs.push_back('{8'h68, 8'h81, 5, 8'h81, 1'b1}); // mvi R5, 81
        vecs.push_back('{8'hAD, 8'h00, 5, 8'h02, 1'b1}); // add R5, R5
        vecs.push_back('{8'h70, 8'h3C, 6, 8'h3C, 1'b0}); // mvi R6, 3C
        vecs.push_back('{8'hF6, 8'h00, 6, 8'h00, 1'b0}); // sub R6, R6
        vecs.push_back('{8'h7F, 8'hA5, 7, 8'hA5, 1'b0}); // mvi R7 (ry field ignored)

        // Reset state
        rst = 1'b1; run = 1'b1; din = 8'h4A;
        #1;
        check("reset_outputs", 32'(actual_ctl()), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_hold_outputs", 32'(actual_ctl()), 32'd0);
        rst = 1'b0; run = 1'b0;

        // Idle: run low keeps T0 with all controls low
        din = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            check("idle_t0", 32'(actual_ctl()), 32'd0);
        end

        // Table-driven instruction stream
        for (int i = 0; i < vecs.size(); i++) begin
            exec(vecs[i].instr, vecs[i].imm, vecs[i].hold);
            check($sformatf("reg_R%0d_after_%h", vecs[i].chk_reg, vecs[i].instr),
                  32'(rf[vecs[i].chk_reg]), 32'(vecs[i].chk_val));
        end
        run = 1'b0;

`ifdef PERF_CNT_EN
        check("instr_cnt_stream", 32'(instr_cnt), 32'(exp_cnt));
`endif

        // Reset mid-instruction: add R0, R1 aborted in T2
        r0_saved = rf[0];
        run = 1'b1; din = 8'h81;
        @(negedge clk);
        w = '0; w.rout = 8'h01; w.ain = 1'b1;
        check("abort_t1", 32'(actual_ctl()), 32'(w));
        @(negedge clk);
        w = '0; w.rout = 8'h02; w.gin = 1'b1; w.addsub = 1'b1;
        check("abort_t2", 32'(actual_ctl()), 32'(w));
        abort_win = 1'b1;
        #2 rst = 1'b1;
        #1 check("abort_rst_outputs", 32'(actual_ctl()), 32'd0);
        @(posedge clk);
        #1 check("abort_rst_edge_outputs", 32'(actual_ctl()), 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; exp_cnt = 0;
        check("abort_release_t0", 32'(actual_ctl()), 32'd0);
        @(negedge clk);
        check("abort_still_t0", 32'(actual_ctl()), 32'd0);
        abort_win = 1'b0;
        check("abort_no_done", 32'(abort_done), 32'd0);
        check("abort_r0_untouched", 32'(rf[0]), 32'(r0_saved));

        // Next instruction after the abort executes normally
        exec(8'h50, 8'h5A, 1'b0); // mvi R2, 5A
        check("post_abort_R2", 32'(rf[2]), 32'h5A);
        run = 1'b0;

`ifdef PERF_CNT_EN
        check("instr_cnt_after_reset", 32'(instr_cnt), 32'(exp_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
